// File: rtl/mage_pkg.sv
// Shared constants, entry layout and FSM state type for the config-stream sequencer.
// The optional RUN timeout length lives here; the feature is enabled by CFG_SEQ_TIMEOUT_EN.
package mage_pkg;

  localparam int ACC_CFGMEM_SIZE        = 4;
  localparam int N_AGE_TOT              = 4;
  localparam int NBIT_CFG_STREAM_WORD   = 8;
  localparam int N_END_CONSTANT         = 7;
  localparam int CFG_SEQ_TIMEOUT_CYCLES = 16;

  typedef logic [N_AGE_TOT-1:0][NBIT_CFG_STREAM_WORD-1:0] cfg_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RUN     = 2'd2,
    ST_ADVANCE = 2'd3
  } seq_state_e;

  // A stream takes part in an entry only when its word carries the valid bit.
  function automatic logic [N_AGE_TOT-1:0] entry_valid_mask(input cfg_entry_t e);
    logic [N_AGE_TOT-1:0] m;
    m = '0;
    for (int s = 0; s < N_AGE_TOT; s++) m[s] = e[s][N_END_CONSTANT];
    return m;
  endfunction

endpackage

// File: rtl/cfg_stream_sequencer_if.sv
// Host-side bus of the config-stream sequencer: entry writes, launch, stream completion and status.
interface cfg_stream_sequencer_if
  import mage_pkg::*;
#(
  parameter int CFG_DEPTH = ACC_CFGMEM_SIZE
);
  logic                           cfg_we_i;
  logic [$clog2(CFG_DEPTH)-1:0]   cfg_waddr_i;
  cfg_entry_t                     cfg_wdata_i;
  logic                           start_i;
  logic [$clog2(CFG_DEPTH):0]     n_cfg_i;
  logic [N_AGE_TOT-1:0]           stream_done_i;
  cfg_entry_t [CFG_DEPTH-1:0]     cfgmem_content_o;
  logic                           stream_start_o;
  logic                           busy_o;
  logic                           seq_done_o;
  logic [$clog2(CFG_DEPTH)-1:0]   cfg_idx_o;
  logic                           wr_err_o;
  logic                           err_timeout_o;

  modport slave (
    input  cfg_we_i, cfg_waddr_i, cfg_wdata_i, start_i, n_cfg_i, stream_done_i,
    output cfgmem_content_o, stream_start_o, busy_o, seq_done_o, cfg_idx_o, wr_err_o, err_timeout_o
  );

  modport master (
    output cfg_we_i, cfg_waddr_i, cfg_wdata_i, start_i, n_cfg_i, stream_done_i,
    input  cfgmem_content_o, stream_start_o, busy_o, seq_done_o, cfg_idx_o, wr_err_o, err_timeout_o
  );
endinterface

// File: rtl/cfg_mem_rotator.sv
// Rotated view of the configuration memory: slot k shows entry (idx + k) mod CFG_DEPTH.
module cfg_mem_rotator
  import mage_pkg::*;
#(
  parameter int CFG_DEPTH = ACC_CFGMEM_SIZE
) (
  input  cfg_entry_t [CFG_DEPTH-1:0]   mem_i,
  input  logic [$clog2(CFG_DEPTH)-1:0] idx_i,
  output cfg_entry_t [CFG_DEPTH-1:0]   view_o
);
  localparam int IW = $clog2(CFG_DEPTH);
  localparam int SW = IW + 1;

  for (genvar gi = 0; gi < CFG_DEPTH; gi++) begin : g_rot
    logic [SW-1:0] sum;
    logic [IW-1:0] ridx;
    // One conditional subtract suffices since idx and gi are both below CFG_DEPTH.
    assign sum       = {1'b0, idx_i} + SW'(gi);
    assign ridx      = IW'((sum >= SW'(CFG_DEPTH)) ? (sum - SW'(CFG_DEPTH)) : sum);
    assign view_o[gi] = mem_i[ridx];
  end
endmodule

// File: rtl/cfg_stream_sequencer.sv
// Walks n_cfg stored entries: settle, launch streams, wait for every valid stream, advance.
// Define CFG_SEQ_TIMEOUT_EN to bound each RUN phase and flag a sticky timeout error.
module cfg_stream_sequencer
  import mage_pkg::*;
#(
  parameter int CFG_DEPTH     = ACC_CFGMEM_SIZE,
  parameter int SETTLE_CYCLES = 3
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  cfg_stream_sequencer_if.slave bus
);
  localparam int IW  = $clog2(CFG_DEPTH);
  localparam int CW  = IW + 1;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_e                 state_q, state_d;
  cfg_entry_t [CFG_DEPTH-1:0] mem_q, mem_d, view;
  logic [IW-1:0]              idx_q, idx_d;
  logic [CW-1:0]              remain_q, remain_d;
  logic [SCW-1:0]             settle_q, settle_d;
  logic [N_AGE_TOT-1:0]       mask_q, mask_d, done_q, done_d, done_nx;
  logic                       start_pulse_q, start_pulse_d;
  logic                       seq_done_q, seq_done_d;
  logic                       wr_err_q, wr_err_d;
`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int TCW = (CFG_SEQ_TIMEOUT_CYCLES > 1) ? $clog2(CFG_SEQ_TIMEOUT_CYCLES) : 1;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           err_tmo_q, err_tmo_d;
`endif

  cfg_mem_rotator #(.CFG_DEPTH(CFG_DEPTH)) u_rotator (
    .mem_i  (mem_q),
    .idx_i  (idx_q),
    .view_o (view)
  );

  // A done pulse on the completing cycle counts, so compare against the merged value.
  assign done_nx = done_q | (bus.stream_done_i & mask_q);

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    idx_d         = idx_q;
    remain_d      = remain_q;
    settle_d      = settle_q;
    mask_d        = mask_q;
    done_d        = done_q;
    start_pulse_d = 1'b0;
    seq_done_d    = 1'b0;
    wr_err_d      = 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_tmo_d     = err_tmo_q;
`endif
    if (bus.cfg_we_i) begin
      if (state_q == ST_IDLE) mem_d[bus.cfg_waddr_i] = bus.cfg_wdata_i;
      else                    wr_err_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
`ifdef CFG_SEQ_TIMEOUT_EN
          err_tmo_d = 1'b0;
`endif
          if (bus.n_cfg_i == '0) begin
            seq_done_d = 1'b1;
          end else begin
            idx_d    = '0;
            remain_d = (bus.n_cfg_i > CW'(CFG_DEPTH)) ? CW'(CFG_DEPTH) : bus.n_cfg_i;
            settle_d = '0;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == SCW'(SETTLE_CYCLES - 1)) begin
          state_d       = ST_RUN;
          start_pulse_d = 1'b1;
          mask_d        = entry_valid_mask(view[0]);
          done_d        = '0;
`ifdef CFG_SEQ_TIMEOUT_EN
          tmo_d         = '0;
`endif
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end
      ST_RUN: begin
        done_d = done_nx;
        if (done_nx == mask_q) begin
          state_d = ST_ADVANCE;
        end
`ifdef CFG_SEQ_TIMEOUT_EN
        else if (tmo_q == TCW'(CFG_SEQ_TIMEOUT_CYCLES - 1)) begin
          err_tmo_d = 1'b1;
          state_d   = ST_ADVANCE;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
`endif
      end
      ST_ADVANCE: begin
        remain_d = remain_q - CW'(1);
        idx_d    = (idx_q == IW'(CFG_DEPTH - 1)) ? '0 : idx_q + IW'(1);
        if (remain_q == CW'(1)) begin
          seq_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      mem_q         <= '0;
      idx_q         <= '0;
      remain_q      <= '0;
      settle_q      <= '0;
      mask_q        <= '0;
      done_q        <= '0;
      start_pulse_q <= 1'b0;
      seq_done_q    <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      idx_q         <= idx_d;
      remain_q      <= remain_d;
      settle_q      <= settle_d;
      mask_q        <= mask_d;
      done_q        <= done_d;
      start_pulse_q <= start_pulse_d;
      seq_done_q    <= seq_done_d;
      wr_err_q      <= wr_err_d;
    end
  end

`ifdef CFG_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign bus.err_timeout_o = err_tmo_q;
`else
  assign bus.err_timeout_o = 1'b0;
`endif

  assign bus.cfgmem_content_o = view;
  assign bus.stream_start_o   = start_pulse_q;
  assign bus.busy_o           = (state_q != ST_IDLE);
  assign bus.seq_done_o       = seq_done_q;
  assign bus.cfg_idx_o        = idx_q;
  assign bus.wr_err_o         = wr_err_q;
endmodule

// File: tb/tb_cfg_stream_sequencer.sv
// Self-checking bench for cfg_stream_sequencer: directed scenarios plus randomized sequences
// checked every cycle against a queue/arithmetic model of the sequencing rules.
`timescale 1ns/1ps
module tb_cfg_stream_sequencer;
  import mage_pkg::*;

  localparam int D      = ACC_CFGMEM_SIZE;
  localparam int NS     = N_AGE_TOT;
  localparam int NB     = NBIT_CFG_STREAM_WORD;
  localparam int EW     = NS * NB;
  localparam int VW     = D * EW;
  localparam int IW     = $clog2(D);
  localparam int SETTLE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cfg_stream_sequencer_if #(.CFG_DEPTH(D)) bus();

  cfg_stream_sequencer #(.CFG_DEPTH(D), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [EW-1:0] m_mem [D];
  int            m_idx, m_left, m_wait, m_run_cyc;
  bit            m_busy, m_run, m_adv, m_start, m_done, m_werr, m_terr;
  logic [NS-1:0] m_pend;

  function automatic logic [NS-1:0] valid_bits(input logic [EW-1:0] e);
    logic [NS-1:0] v;
    for (int s = 0; s < NS; s++) v[s] = e[s*NB + N_END_CONSTANT];
    return v;
  endfunction

  function automatic logic [VW-1:0] m_view();
    logic [VW-1:0] v;
    for (int k = 0; k < D; k++) v[k*EW +: EW] = m_mem[(m_idx + k) % D];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_idx = 0; m_left = 0; m_wait = 0; m_run_cyc = 0; m_pend = '0;
    m_busy = 0; m_run = 0; m_adv = 0; m_start = 0; m_done = 0; m_werr = 0; m_terr = 0;
  endtask

  task automatic m_step();
    m_start = 0; m_done = 0; m_werr = 0;
    if (bus.cfg_we_i) begin
      if (m_busy) m_werr = 1;
      else        m_mem[bus.cfg_waddr_i] = bus.cfg_wdata_i;
    end
    if (!m_busy) begin
      if (bus.start_i) begin
        m_terr = 0;
        if (bus.n_cfg_i == 0) m_done = 1;
        else begin
          m_idx  = 0;
          m_left = (int'(bus.n_cfg_i) > D) ? D : int'(bus.n_cfg_i);
          m_busy = 1;
          m_wait = SETTLE;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_start = 1; m_run = 1; m_run_cyc = 0;
        m_pend = valid_bits(m_mem[m_idx]);
      end
    end else if (m_run) begin
      m_pend = m_pend & ~bus.stream_done_i;
      m_run_cyc++;
      if (m_pend == 0) begin
        m_run = 0; m_adv = 1;
      end
`ifdef CFG_SEQ_TIMEOUT_EN
      else if (m_run_cyc == CFG_SEQ_TIMEOUT_CYCLES) begin
        m_terr = 1; m_run = 0; m_adv = 1;
      end
`endif
    end else if (m_adv) begin
      m_adv = 0;
      m_left--;
      m_idx = (m_idx + 1) % D;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_wait = SETTLE;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stream_start", VW'(bus.stream_start_o), VW'(m_start));
      chk("seq_done",     VW'(bus.seq_done_o),     VW'(m_done));
      chk("busy",         VW'(bus.busy_o),         VW'(m_busy));
      chk("cfg_idx",      VW'(bus.cfg_idx_o),      VW'(m_idx));
      chk("wr_err",       VW'(bus.wr_err_o),       VW'(m_werr));
      chk("err_timeout",  VW'(bus.err_timeout_o),  VW'(m_terr));
      chk("cfgmem_view",  bus.cfgmem_content_o,    m_view());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.cfg_we_i = 0; bus.cfg_waddr_i = '0; bus.cfg_wdata_i = '0;
    bus.start_i = 0; bus.n_cfg_i = '0; bus.stream_done_i = '0;
  endtask

  task automatic write_entry(input int a, input logic [EW-1:0] w);
    bus.cfg_we_i = 1; bus.cfg_waddr_i = IW'(a); bus.cfg_wdata_i = w;
    tick();
    bus.cfg_we_i = 0;
  endtask

  task automatic launch(input int n);
    bus.start_i = 1; bus.n_cfg_i = (IW+1)'(n);
    tick();
    bus.start_i = 0;
  endtask

  task automatic wait_for(input string name, input bit want_done, input int max);
    int n = 0;
    while (((want_done ? bus.seq_done_o : bus.stream_start_o) !== 1'b1) && n < max) begin
      tick();
      n++;
    end
    chk(name, VW'(n < max), VW'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1;

    // Reset state.
    chk("rst_busy", VW'(bus.busy_o), VW'(0));
    chk("rst_idx",  VW'(bus.cfg_idx_o), VW'(0));
    chk("rst_view", bus.cfgmem_content_o, VW'(0));

    // Two all-valid entries: settle latency, advance, second launch, completion.
    write_entry(0, 32'h80808080);
    write_entry(1, 32'h81828384);
    launch(2);
    chk("seq1_busy_after_start", VW'(bus.busy_o), VW'(1));
    tick(); tick();
    chk("seq1_no_early_start", VW'(bus.stream_start_o), VW'(0));
    tick();
    chk("seq1_start_at_latency", VW'(bus.stream_start_o), VW'(1));
    bus.stream_done_i = 4'hF;
    tick();
    bus.stream_done_i = '0;
    tick();
    chk("seq1_idx_after_adv", VW'(bus.cfg_idx_o), VW'(1));
    tick(); tick(); tick();
    chk("seq1_second_start", VW'(bus.stream_start_o), VW'(1));
    bus.stream_done_i = 4'hF;
    tick();
    bus.stream_done_i = '0;
    tick();
    chk("seq1_done", VW'(bus.seq_done_o), VW'(1));
    chk("seq1_idle", VW'(bus.busy_o), VW'(0));

    // Mask 0101: partial done holds RUN, write during RUN is rejected.
    write_entry(0, 32'h00800080);
    launch(1);
    wait_for("seq2_wait_start", 0, 10);
    bus.stream_done_i = 4'b0010;
    tick();
    bus.stream_done_i = '0;
    tick(); tick();
    chk("seq2_still_run", VW'(bus.busy_o), VW'(1));
    bus.cfg_we_i = 1; bus.cfg_waddr_i = '0; bus.cfg_wdata_i = 32'hDEADBEEF;
    tick();
    bus.cfg_we_i = 0;
    chk("seq2_wr_err_pulse", VW'(bus.wr_err_o), VW'(1));
    tick();
    chk("seq2_wr_err_single", VW'(bus.wr_err_o), VW'(0));
    bus.stream_done_i = 4'b0101;
    tick();
    bus.stream_done_i = '0;
    chk("seq2_adv_no_done_yet", VW'(bus.seq_done_o), VW'(0));
    tick();
    chk("seq2_done", VW'(bus.seq_done_o), VW'(1));
    chk("seq2_mem_kept", VW'(bus.cfgmem_content_o[D-1]), VW'(32'h00800080));

    // Over-long count saturates to the memory depth; index wraps to 0.
    for (int i = 0; i < D; i++) write_entry(i, 32'h00000000);
    launch(D + 3);
    cnt = 0; seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (bus.stream_start_o) cnt++;
      if (bus.seq_done_o) seen = 1;
      else tick();
    end
    chk("sat_seen_done", VW'(seen), VW'(1));
    chk("sat_start_count", VW'(cnt), VW'(D));
    chk("sat_idx_wrap", VW'(bus.cfg_idx_o), VW'(0));
    tick();

    // Asynchronous reset mid-RUN aborts silently.
    write_entry(0, 32'h80808080);
    launch(1);
    wait_for("rst_wait_start", 0, 10);
    tick();
    #2 rst_n = 0;
    #1;
    chk("midrst_busy",  VW'(bus.busy_o), VW'(0));
    chk("midrst_idx",   VW'(bus.cfg_idx_o), VW'(0));
    chk("midrst_view",  bus.cfgmem_content_o, VW'(0));
    chk("midrst_start", VW'(bus.stream_start_o), VW'(0));
    tick(); tick();
    chk("midrst_no_done", VW'(bus.seq_done_o), VW'(0));
    rst_n = 1;
    tick();
    launch(0);
    chk("zero_cnt_done",     VW'(bus.seq_done_o), VW'(1));
    chk("zero_cnt_no_start", VW'(bus.stream_start_o), VW'(0));
    tick();
    chk("zero_cnt_done_single", VW'(bus.seq_done_o), VW'(0));

`ifdef CFG_SEQ_TIMEOUT_EN
    // Silent streams: timeout flags and the sequence still completes; next start clears it.
    write_entry(0, 32'h80808080);
    launch(1);
    wait_for("tmo_wait_done", 1, SETTLE + CFG_SEQ_TIMEOUT_CYCLES + 10);
    chk("tmo_flag", VW'(bus.err_timeout_o), VW'(1));
    tick();
    launch(0);
    chk("tmo_cleared", VW'(bus.err_timeout_o), VW'(0));
`endif

    // Randomized sequences, checked cycle by cycle against the model.
    for (int it = 0; it < 40; it++) begin
      int budget;
      repeat ($urandom_range(0, 3)) write_entry($urandom_range(0, D-1), EW'($urandom));
      launch($urandom_range(0, D + 3));
      budget = 0;
      while (m_busy && budget < 2000) begin
        bus.stream_done_i = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
        bus.cfg_we_i      = ($urandom_range(0, 15) == 0);
        bus.cfg_waddr_i   = IW'($urandom);
        bus.cfg_wdata_i   = EW'($urandom);
        bus.start_i       = ($urandom_range(0, 15) == 0);
        bus.n_cfg_i       = (IW+1)'($urandom);
        tick();
        budget++;
      end
      idle_inputs();
      chk("rand_seq_finished", VW'(m_busy), VW'(0));
      tick();
    end

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cfg_stream_sequencer.md
CFG_STREAM_SEQUENCER -- requirements
Module: cfg_stream_sequencer

Interface
REQ-001 SHALL have parameter CFG_DEPTH, default ACC_CFGMEM_SIZE, meaning the number of configuration entries.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 3, meaning the dispatcher pipeline depth to wait before start.
REQ-003 SHALL have ports: clk_i in 1 clock; rst_n_i in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: cfg_we_i in 1 entry write strobe; cfg_waddr_i in $clog2(CFG_DEPTH) entry index; cfg_wdata_i in N_AGE_TOT*NBIT_CFG_STREAM_WORD one full entry.
REQ-005 SHALL have ports: start_i in 1 sequence launch; n_cfg_i in $clog2(CFG_DEPTH)+1 number of entries to run; stream_done_i in N_AGE_TOT per-stream completion pulse.
REQ-006 SHALL have ports: cfgmem_content_o out [CFG_DEPTH][N_AGE_TOT][NBIT_CFG_STREAM_WORD] rotated memory view; stream_start_o out 1; busy_o out 1; seq_done_o out 1; cfg_idx_o out $clog2(CFG_DEPTH) current entry; wr_err_o out 1; err_timeout_o out 1.

Function
REQ-007 SHALL drive cfgmem_content_o[k] = mem[(cfg_idx_o+k) mod CFG_DEPTH], so index 0 is always the active entry.
REQ-008 SHALL accept cfg_we_i only in IDLE, writing the entry on the same edge; cfg_we_i in any other state SHALL be ignored and pulse wr_err_o for one cycle.
REQ-009 SHALL implement FSM IDLE -> SETTLE -> RUN -> ADVANCE -> (SETTLE | IDLE).
REQ-010 IDLE: on start_i with n_cfg_i != 0, SHALL clear cfg_idx_o, load the remaining-entry counter with n_cfg_i, and enter SETTLE; start_i with n_cfg_i == 0 SHALL pulse seq_done_o the next cycle and stay IDLE.
REQ-011 SETTLE: SHALL count SETTLE_CYCLES cycles, then pulse stream_start_o for exactly one cycle on entry to RUN.
REQ-012 On RUN entry SHALL latch the active mask from bit N_END_CONSTANT of each stream word of the active entry and clear the done-tracking register.
REQ-013 RUN: SHALL OR stream_done_i masked by the active mask into the done register; when the register equals the mask (including a done pulse on that same cycle) SHALL enter ADVANCE.
REQ-014 An entry with an all-zero active mask SHALL advance directly to ADVANCE one cycle after RUN entry.
REQ-015 ADVANCE: SHALL decrement the remaining counter and increment cfg_idx_o modulo CFG_DEPTH; if the counter reaches zero, SHALL pulse seq_done_o and return to IDLE, else SHALL return to SETTLE.
REQ-016 n_cfg_i > CFG_DEPTH SHALL be saturated to CFG_DEPTH at launch.
REQ-017 busy_o SHALL be high in every state except IDLE; start_i while busy SHALL be ignored.
REQ-018 stream_done_i for streams outside the active mask, or outside RUN, SHALL be ignored.

Reset
REQ-019 On rst_n_i low, SHALL enter IDLE and clear cfg_idx_o, all counters, the masks, stream_start_o, seq_done_o, wr_err_o and err_timeout_o; memory contents SHALL be cleared to zero.
REQ-020 Reset asserted mid-sequence SHALL abort without a seq_done_o pulse.

Configuration
REQ-021 With CFG_SEQ_TIMEOUT_EN defined, SHALL count RUN cycles per entry; reaching CFG_SEQ_TIMEOUT_CYCLES SHALL set sticky err_timeout_o (cleared by next start_i) and force ADVANCE.
REQ-022 Without CFG_SEQ_TIMEOUT_EN, err_timeout_o SHALL be tied 0 and RUN SHALL wait indefinitely.

Structure
REQ-023 The FSM state enum, CFG_SEQ_TIMEOUT_CYCLES, and the valid-bit position (N_END_CONSTANT) SHALL live in mage_pkg.
REQ-024 The rotated-view mux SHALL be a sub-module cfg_mem_rotator; all other logic SHALL be in the top module.

Verification
REQ-025 Write 2 entries with all streams valid, start_i with n_cfg_i=2 -> stream_start_o exactly 3 cycles after start_i+1; after all stream_done_i, cfg_idx_o=1, second start_o, then seq_done_o, busy_o low.
REQ-026 Active mask 0b0101; pulse done on stream 1 only -> remains in RUN; then streams 0 and 2 on the same cycle -> ADVANCE next cycle.
REQ-027 cfg_we_i during RUN -> wr_err_o single-cycle pulse; memory unchanged (read back via cfgmem_content_o).
REQ-028 n_cfg_i=CFG_DEPTH+3 -> exactly CFG_DEPTH start pulses; cfg_idx_o wraps to 0 at end.
REQ-029 Assert rst_n_i low mid-RUN -> all outputs zero immediately, no seq_done_o; n_cfg_i=0 start -> seq_done_o next cycle, no stream_start_o.
REQ-030 With CFG_SEQ_TIMEOUT_EN, never pulse done -> err_timeout_o set after CFG_SEQ_TIMEOUT_CYCLES, sequence advances; cleared on next start_i.
